// File: rtl/sopc_motor1_cmd.sv
// sopc_motor1_cmd: Avalon-MM command slave for motor 1.
// The CPU writes duty, period and control words. The block produces a
// registered PWM, direction and brake drive. New duty and period values
// take effect only at period boundaries. When the direction reverses
// while the motor is running, a dead-time is inserted first.

module sopc_motor1_cmd #(
    parameter int CNT_W    = 16,
    parameter int DEADTIME = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        pwm_out,
    output logic        dir_out,
    output logic        brake_out
);

    localparam int DEAD_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEADTIME - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   duty_q, period_q;
    logic               ctrl_en_q, ctrl_dir_q, ctrl_brake_q;
    logic [CNT_W-1:0]   duty_a_q, duty_a_d;
    logic [CNT_W-1:0]   period_a_q, period_a_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DEAD_W-1:0]  dead_q, dead_d;
    logic               pwm_q, pwm_d;
    logic               dir_out_q, dir_out_d;
    logic               brake_out_q;
    logic [31:0]        rdata_q;
    logic [31:0]        rdata_s;
    logic [15:0]        cnt16_s;
    logic               wr_en_s;
    logic               run_ok_s;
    logic               dir_diff_s;
    logic               dead_done_s;
    logic               wrap_s;
    logic [CNT_W-1:0]   cnt_inc_s;
    logic               unused_wdata_s;

    assign wr_en_s        = chipselect & ~write_n;
    assign run_ok_s       = ctrl_en_q & ~ctrl_brake_q;
    assign dir_diff_s     = (ctrl_dir_q != dir_out_q);
    assign dead_done_s    = (dead_q == DEAD_LAST);
    assign wrap_s         = (cnt_q == period_a_q);
    assign cnt_inc_s      = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    assign unused_wdata_s = ^writedata;

    // Counter field of STATUS is always 16 bits wide.
    if (CNT_W >= 16) begin : g_cnt_trunc
        assign cnt16_s = cnt_q[15:0];
    end else begin : g_cnt_ext
        assign cnt16_s = {{(16-CNT_W){1'b0}}, cnt_q};
    end

    // Software-visible pending registers, loaded by bus writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_q       <= '0;
            period_q     <= '0;
            ctrl_en_q    <= 1'b0;
            ctrl_dir_q   <= 1'b0;
            ctrl_brake_q <= 1'b0;
        end else if (wr_en_s) begin
            case (address)
                2'd0: duty_q   <= writedata[CNT_W-1:0];
                2'd1: period_q <= writedata[CNT_W-1:0];
                2'd2: begin
                    ctrl_en_q    <= writedata[0];
                    ctrl_dir_q   <= writedata[1];
                    ctrl_brake_q <= writedata[2];
                end
                default: ; // STATUS is read-only
            endcase
        end
    end

    // Read mux. It reflects register contents before any write on this edge.
    always_comb begin
        rdata_s = 32'd0;
        case (address)
            2'd0:    rdata_s = 32'(duty_q);
            2'd1:    rdata_s = 32'(period_q);
            2'd2:    rdata_s = {29'd0, ctrl_brake_q, ctrl_dir_q, ctrl_en_q};
            default: rdata_s = {cnt16_s, 13'd0, (state_q == ST_DEAD),
                                dir_out_q, (state_q == ST_RUN)};
        endcase
    end

    // Registered read data (latency one cycle).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= 32'd0;
        end else begin
            rdata_q <= rdata_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state. Disable or brake always wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (run_ok_s) state_d = ST_RUN;
                else          state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (!run_ok_s)      state_d = ST_IDLE;
                else if (dir_diff_s) state_d = ST_DEAD;
                else                 state_d = ST_RUN;
            end
            ST_DEAD: begin
                if (!run_ok_s)       state_d = ST_IDLE;
                else if (dead_done_s) state_d = ST_RUN;
                else                  state_d = ST_DEAD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs. Computes next counter, active values and pin levels.
    // pwm_q always equals (cnt_q < duty_a_q) while in RUN.
    always_comb begin
        cnt_d      = cnt_q;
        dead_d     = dead_q;
        duty_a_d   = duty_a_q;
        period_a_d = period_a_q;
        pwm_d      = 1'b0;
        dir_out_d  = dir_out_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                dead_d    = '0;
                dir_out_d = ctrl_dir_q;
                if (run_ok_s) begin
                    duty_a_d   = duty_q;
                    period_a_d = period_q;
                    pwm_d      = (duty_q != '0);
                end else begin
                    pwm_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (!run_ok_s || dir_diff_s) begin
                    cnt_d  = '0;
                    dead_d = '0;
                    pwm_d  = 1'b0;
                end else if (wrap_s) begin
                    cnt_d      = '0;
                    duty_a_d   = duty_q;
                    period_a_d = period_q;
                    pwm_d      = (duty_q != '0);
                end else begin
                    cnt_d = cnt_inc_s;
                    pwm_d = (cnt_inc_s < duty_a_q);
                end
            end
            ST_DEAD: begin
                if (!run_ok_s) begin
                    cnt_d  = '0;
                    dead_d = '0;
                    pwm_d  = 1'b0;
                end else if (dead_done_s) begin
                    cnt_d      = '0;
                    dead_d     = '0;
                    dir_out_d  = ctrl_dir_q;
                    duty_a_d   = duty_q;
                    period_a_d = period_q;
                    pwm_d      = (duty_q != '0);
                end else begin
                    dead_d = dead_q + {{(DEAD_W-1){1'b0}}, 1'b1};
                    pwm_d  = 1'b0;
                end
            end
            default: begin
                cnt_d  = '0;
                dead_d = '0;
                pwm_d  = 1'b0;
            end
        endcase
    end

    // Datapath and motor pin registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            dead_q      <= '0;
            duty_a_q    <= '0;
            period_a_q  <= '0;
            pwm_q       <= 1'b0;
            dir_out_q   <= 1'b0;
            brake_out_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            dead_q      <= dead_d;
            duty_a_q    <= duty_a_d;
            period_a_q  <= period_a_d;
            pwm_q       <= pwm_d;
            dir_out_q   <= dir_out_d;
            brake_out_q <= ctrl_brake_q;
        end
    end

    assign readdata  = rdata_q;
    assign pwm_out   = pwm_q;
    assign dir_out   = dir_out_q;
    assign brake_out = brake_out_q;

endmodule

// File: tb/tb_sopc_motor1_cmd.sv
// Bench for sopc_motor1_cmd. It runs directed scenarios, then random bus
// traffic. Every cycle the DUT outputs are compared with a behavioural
// model of the motor command port.

module tb_sopc_motor1_cmd;

    localparam int CNT_W    = 16;
    localparam int DEADTIME = 64;
    localparam int M_IDLE = 0, M_RUN = 1, M_DEAD = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        pwm_out, dir_out, brake_out;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state
    int unsigned m_duty, m_period, m_duty_a, m_period_a, m_pos, m_dead_elapsed;
    logic        m_en, m_dir, m_brake, m_dirout, m_brk;
    int          m_mode;
    logic [31:0] m_rd;

    sopc_motor1_cmd #(.CNT_W(CNT_W), .DEADTIME(DEADTIME)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .pwm_out    (pwm_out),
        .dir_out    (dir_out),
        .brake_out  (brake_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_duty = 0; m_period = 0; m_duty_a = 0; m_period_a = 0;
        m_pos = 0; m_dead_elapsed = 0;
        m_en = 1'b0; m_dir = 1'b0; m_brake = 1'b0;
        m_dirout = 1'b0; m_brk = 1'b0; m_mode = M_IDLE; m_rd = 32'd0;
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = 32'd0;
        s[31:16] = 16'(m_pos);
        s[2] = (m_mode == M_DEAD);
        s[1] = m_dirout;
        s[0] = (m_mode == M_RUN);
        return s;
    endfunction

    task automatic load_active();
        m_duty_a   = m_duty;
        m_period_a = m_period;
    endtask

    // One clock edge of the reference model, using the bus inputs held
    // across that edge. Control decisions use CTRL as it was before the edge.
    task automatic model_step();
        logic go;
        logic [31:0] rd;
        case (address)
            2'd0:    rd = m_duty;
            2'd1:    rd = m_period;
            2'd2:    rd = {29'd0, m_brake, m_dir, m_en};
            default: rd = m_status();
        endcase
        go = m_en && !m_brake;
        m_brk = m_brake;
        if (m_mode == M_IDLE) begin
            m_dirout = m_dir;
            m_pos = 0;
            if (go) begin
                m_mode = M_RUN;
                load_active();
            end
        end else if (!go) begin
            m_mode = M_IDLE;
            m_pos = 0;
        end else if (m_mode == M_RUN) begin
            if (m_dir != m_dirout) begin
                m_mode = M_DEAD;
                m_pos = 0;
                m_dead_elapsed = 0;
            end else if (m_pos == m_period_a) begin
                m_pos = 0;
                load_active();
            end else begin
                m_pos = m_pos + 1;
            end
        end else begin
            if (m_dead_elapsed == DEADTIME - 1) begin
                m_dirout = m_dir;
                m_mode = M_RUN;
                m_pos = 0;
                load_active();
            end else begin
                m_dead_elapsed = m_dead_elapsed + 1;
            end
        end
        if (chipselect && !write_n) begin
            case (address)
                2'd0: m_duty   = writedata & 32'h0000_FFFF;
                2'd1: m_period = writedata & 32'h0000_FFFF;
                2'd2: begin
                    m_en = writedata[0]; m_dir = writedata[1]; m_brake = writedata[2];
                end
                default: ;
            endcase
        end
        m_rd = rd;
    endtask

    task automatic check_all();
        logic exp_pwm;
        exp_pwm = (m_mode == M_RUN) && (m_pos < m_duty_a);
        chk("pwm_out", 32'(pwm_out), 32'(exp_pwm));
        chk("dir_out", 32'(dir_out), 32'(m_dirout));
        chk("brake_out", 32'(brake_out), 32'(m_brk));
        chk("readdata", readdata, m_rd);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        chipselect = 1'b0; write_n = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        tick();
    endtask

    initial begin
        int guard;
        logic [1:0] ra;
        logic [31:0] rv;
        model_reset();
        // Power-on reset
        repeat (3) @(posedge clk);
        #3;
        chk("rst_pwm", 32'(pwm_out), 32'd0);
        chk("rst_readdata", readdata, 32'd0);
        reset_n = 1'b1;

        // Basic PWM: period 9, duty 3
        address = 2'd3;
        bus_write(2'd1, 32'd9);
        bus_write(2'd0, 32'd3);
        bus_write(2'd2, 32'd1);
        address = 2'd3;
        idle(25);

        // Mid-period duty change, then constant-high and constant-low duties
        guard = 0;
        while (m_pos != 4 && guard < 50) begin
            tick();
            guard++;
        end
        chk("wait_cnt4", 32'(guard < 50), 32'd1);
        bus_write(2'd0, 32'd7);
        address = 2'd3;
        idle(25);
        bus_write(2'd0, 32'd12);
        idle(25);
        bus_write(2'd0, 32'd0);
        idle(25);
        bus_write(2'd0, 32'd3);
        idle(12);

        // Reversal with dead-time
        bus_write(2'd2, 32'd3);
        address = 2'd3;
        idle(80);

        // Reverse again, then brake during the dead-time
        bus_write(2'd2, 32'd1);
        idle(10);
        bus_write(2'd2, 32'd5);
        idle(4);

        // Reset asserted while running
        bus_write(2'd2, 32'd1);
        idle(10);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_pwm", 32'(pwm_out), 32'd0);
        chk("arst_dir", 32'(dir_out), 32'd0);
        chk("arst_brake", 32'(brake_out), 32'd0);
        chk("arst_readdata", readdata, 32'd0);
        model_reset();
        @(posedge clk);
        #3 reset_n = 1'b1;
        address = 2'd3;
        tick();
        chk("status_after_reset", readdata, 32'd0);

        // Bus: write to read-only STATUS, then read everything back
        bus_write(2'd0, 32'hDEAD_0005);
        bus_write(2'd1, 32'hBEEF_0011);
        bus_write(2'd2, 32'hFFFF_FFF9);
        bus_write(2'd3, 32'hFFFF_FFFF);
        for (int a = 0; a < 4; a++) bus_read(2'(a));
        idle(3);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            ra = 2'($urandom_range(0, 3));
            address = ra;
            chipselect = ($urandom_range(0, 3) != 0);
            write_n = ($urandom_range(0, 5) != 0);
            rv = $urandom();
            case (ra)
                2'd0: writedata = ($urandom_range(0, 3) == 0) ? rv : ((rv & 32'hFFFF_0000) | 32'($urandom_range(0, 14)));
                2'd1: writedata = (rv & 32'hFFFF_0000) | 32'($urandom_range(0, 12));
                2'd2: writedata = (rv & 32'hFFFF_FFF8)
                                | {29'd0, ($urandom_range(0, 14) == 0),
                                   (($urandom_range(0, 2) == 0) ? ~m_dir : m_dir),
                                   ($urandom_range(0, 9) != 0)};
                default: writedata = rv;
            endcase
            tick();
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sopc_motor1_cmd.md
# sopc_motor1_cmd

Avalon-MM write/read slave that turns CPU motor commands into a PWM, direction and brake drive for motor 1. It is the command-side counterpart of the motor 1 feedback input port and sits on the same SOPC bus. Software writes duty, period and control words. The block generates the PWM waveform, updates duty and period only on period boundaries, and inserts a dead-time when the direction reverses under drive.

## Interface
Parameters:
- `CNT_W`, 16: width of the PWM counter, duty and period fields.
- `DEADTIME`, 64: number of clk cycles `pwm_out` is held low before `dir_out` reverses while running (must be ≥1).

Ports:
- `clk`  in  1  system clock; the single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  2  register select.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe, qualified by `chipselect`.
- `writedata`  in  32  write data.
- `readdata`  out  32  registered read data.
- `pwm_out`  out  1  PWM drive.
- `dir_out`  out  1  motor direction.
- `brake_out`  out  1  brake request.

## Operation
- Register map:
  - addr 0 DUTY[CNT_W-1:0], read/write, pending value.
  - addr 1 PERIOD[CNT_W-1:0], read/write, pending value.
  - addr 2 CTRL: bit0 `en`, bit1 `dir`, bit2 `brake`; read/write.
  - addr 3 STATUS, read-only:
    - bit0 = state is RUN
    - bit1 = `dir_out`
    - bit2 = state is DEAD
    - [31:16] = PWM counter, zero-extended or truncated to 16 bits.
  - Unused bits read 0. Writes to addr 3 are ignored.
- A write occurs on a clk edge with `chipselect`=1 and `write_n`=0, and loads `writedata[...]` into the addressed register.
- Active registers: `duty_a` and `period_a` are copied from the pending registers in three cases:
  - on IDLE→RUN;
  - on DEAD→RUN;
  - in RUN, at wrap (the counter equals `period_a`).
- PWM counter in RUN:
  - counts 0..`period_a`, then wraps to 0.
  - `pwm_out` = (counter < `duty_a`).
  - `duty_a` > `period_a` gives a constant high output.
  - `duty_a`=0 gives a constant low output.
  - `period_a`=0: the counter stays 0 and a wrap occurs every cycle.
- FSM states: IDLE, RUN, DEAD.
  - IDLE: `pwm_out`=0 and the counter is held at 0. `dir_out` follows CTRL.dir. If `en`=1 and `brake`=0, go to RUN with the counter at 0.
  - RUN: if `en`=0 or `brake`=1, go to IDLE, which has priority over everything else. Otherwise, if CTRL.dir ≠ `dir_out`, go to DEAD with `pwm_out`=0 and the dead counter at 0.
  - DEAD: `pwm_out`=0. If `en`=0 or `brake`=1, go to IDLE; `dir_out` then follows CTRL.dir from IDLE. If the dead counter reaches DEADTIME-1, set `dir_out`=CTRL.dir, reset the counter to 0 and go to RUN. If CTRL.dir returns to equal `dir_out` during DEAD, the dead-time still completes and the block then returns to RUN.
- `brake_out` = CTRL.brake, registered.
- Reset: all registers, counters and outputs are 0, and the state is IDLE.

## Timing
- A write at edge k makes the register value visible at edge k. The FSM acts on it at edge k+1. `pwm_out`, `dir_out`, `brake_out` and the state change after edge k+1.
- `readdata` is registered from `address` on every edge (read latency 1) and is 0 on reset. A read and a write to the same address on the same edge return the old value.
- All outputs are registered. There are no combinational paths from the bus to the motor pins.
- Entering RUN gives `pwm_out` = (0 < duty) in the first RUN cycle.
- Reversing in RUN: `pwm_out` is low for exactly DEADTIME cycles. `dir_out` toggles together with the first RUN cycle after DEAD.
- Duty or period writes mid-period take effect in the cycle after the wrap. The current period is never truncated.
- `reset_n` asserted mid-operation forces the outputs low immediately (asynchronously).

## Test plan
- Reset: assert `reset_n`=0 mid-RUN → `pwm_out`, `dir_out`, `brake_out` and `readdata` are 0 immediately. After release, the state is IDLE and reading addr 3 returns 0.
- PWM: PERIOD=9, DUTY=3, CTRL=1 → after 2 cycles, repeating 3 high / 7 low. STATUS bit0=1 and the counter field cycles 0..9.
- Boundary update: write DUTY=7 when the counter is 4 → the current period still ends with DUTY 3. The next period shows 7 high / 3 low. DUTY=12 → constant high. DUTY=0 → constant low.
- Reversal: in RUN, write CTRL=3 (DEADTIME=64) → `pwm_out`=0 for exactly 64 cycles with STATUS bit2=1. `dir_out` then rises and PWM restarts at counter 0.
- Brake/disable priority: in DEAD, write CTRL=5 → IDLE next cycle, `pwm_out`=0, `brake_out`=1, and `dir_out` equals 0 (CTRL.dir) one cycle later.
- Bus: write 0xFFFFFFFF to addr 3, then read addr 0..3 → the writes were ignored, unused bits read 0, and data appears one cycle after `address`.
